// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller owns the master side; the datapath (or bench) owns the slave side.
interface multicycle_controller_if #(
  parameter int INSTRET_W = 32
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic [1:0]           result_src;
  logic [2:0]           alu_control;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           imm_src;
  logic                 reg_write;
  logic                 instr_done;
  logic                 illegal;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
           alu_src_a, alu_src_b, imm_src, reg_write, instr_done, illegal, instret
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
           alu_src_a, alu_src_b, imm_src, reg_write, instr_done, illegal, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath select.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         INSTRET_W   = 32
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  typedef struct packed {
    logic       fetch;
    logic       decode;
    logic       beq;
    logic       jal;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       done;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t               state;
  state_t               next_state;
  ctrl_t                ctrl;
  logic [INSTRET_W-1:0] count;
  logic                 op_legal;
  logic                 done;

  // Per-state control word; registered alongside the state so selects come straight off flops.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.fetch = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      DECODE:   begin c.decode = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  begin c.adr_src = 1'b1; end
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; c.done = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
      BEQ:      begin c.beq = 1'b1; c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.done = 1'b1; end
      JAL:      begin c.jal = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = bus.op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = bus.mem_ready ? FETCH : MEMWRITE;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      BEQ:      next_state = FETCH;
      JAL:      next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  assign done = ctrl.done | (ctrl.mem_write & bus.mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= state_t'(RESET_STATE);
      ctrl  <= decode_ctrl(state_t'(RESET_STATE));
      count <= '0;
    end else begin
      state <= next_state;
      ctrl  <= decode_ctrl(next_state);
      if (done)
        count <= count + 1'b1;
    end
  end

  // Only the funct3=000 R-type case can become a subtract; I-type addi ignores Instr[30].
  always_comb begin
    bus.alu_control = 3'b000;
    case (ctrl.alu_op)
      2'b01: bus.alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.alu_control = 3'b101;
          3'b110:  bus.alu_control = 3'b011;
          3'b111:  bus.alu_control = 3'b010;
          default: bus.alu_control = 3'b000;
        endcase
      end
      default: bus.alu_control = 3'b000;
    endcase
  end

  always_comb begin
    bus.imm_src = 2'b00;
    case (bus.op)
      OP_SW:   bus.imm_src = 2'b01;
      OP_BEQ:  bus.imm_src = 2'b10;
      OP_JAL:  bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

  assign bus.pc_write   = ~reset & ((ctrl.fetch & bus.mem_ready) | ctrl.jal | (ctrl.beq & bus.zero));
  assign bus.ir_write   = ~reset & ctrl.fetch & bus.mem_ready;
  assign bus.adr_src    = ctrl.adr_src;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.result_src = ctrl.result_src;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.instr_done = done;
  assign bus.illegal    = ctrl.decode & ~op_legal;
  assign bus.instret    = count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle
// against hand-written control vectors and checks the retired-instruction count.
module tb_multicycle_controller;

  logic clk;
  logic reset;
  int   testsRun;
  int   failCount;

  multicycle_controller_if #(.INSTRET_W(32)) bus ();

  multicycle_controller #(.RESET_STATE(4'd0), .INSTRET_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input logic mr);
    bus.op        = o;
    bus.funct3    = f3;
    bus.funct7b5  = f7;
    bus.zero      = z;
    bus.mem_ready = mr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Vector order: pc_write adr_src mem_write ir_write result_src alu_control alu_src_a alu_src_b imm_src reg_write instr_done illegal
  task automatic checkCycle(input string tag, input logic pw, adr, mw, irw,
                            input logic [1:0] rs, input logic [2:0] ac,
                            input logic [1:0] sa, sb, imm, input logic rw, dn, ill);
    logic [17:0] obs;
    logic [17:0] expv;
    #1;
    obs  = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
            bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
            bus.reg_write, bus.instr_done, bus.illegal};
    expv = {pw, adr, mw, irw, rs, ac, sa, sb, imm, rw, dn, ill};
    checkOutput(tag, {14'd0, obs}, {14'd0, expv});
  endtask

  task automatic runAlu(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic [2:0] ac, input logic [1:0] sb, input int count);
    applyStimulus(o, f3, f7, 1'b0, 1'b1);
    checkCycle({tag, "_fetch"}, 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    nextCycle();
    checkCycle({tag, "_decode"}, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0);
    nextCycle();
    checkCycle({tag, "_exec"}, 0, 0, 0, 0, 2'b00, ac, 2'b10, sb, 2'b00, 0, 0, 0);
    nextCycle();
    checkCycle({tag, "_wb"}, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    nextCycle();
    checkOutput({tag, "_instret"}, bus.instret, count);
  endtask

  task automatic runBeq(input string tag, input logic z, input int count);
    applyStimulus(7'b1100011, 3'b000, 1'b0, z, 1'b1);
    checkCycle({tag, "_fetch"}, 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 2'b10, 0, 0, 0);
    nextCycle();
    checkCycle({tag, "_decode"}, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b10, 0, 0, 0);
    nextCycle();
    checkCycle({tag, "_beq"}, z, 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b00, 2'b10, 0, 1, 0);
    nextCycle();
    checkOutput({tag, "_instret"}, bus.instret, count);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    reset     = 1'b1;
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);

    // Reset: enables held low even with mem_ready high, selects at FETCH values
    checkCycle("reset_vec", 0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    checkOutput("reset_instret", bus.instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // lw x6,-4(x9): 5 cycles
    checkCycle("lw_fetch", 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    nextCycle();
    checkCycle("lw_decode", 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0);
    nextCycle();
    checkCycle("lw_memadr", 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0);
    nextCycle();
    checkCycle("lw_memread", 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    nextCycle();
    checkCycle("lw_memwb", 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    nextCycle();
    checkOutput("lw_instret", bus.instret, 32'd1);

    // sw x6,8(x9) with two wait cycles: 6 cycles, done only in the ready cycle
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    checkCycle("sw_fetch", 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 2'b01, 0, 0, 0);
    nextCycle();
    checkCycle("sw_decode", 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b01, 0, 0, 0);
    nextCycle();
    checkCycle("sw_memadr", 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b01, 0, 0, 0);
    nextCycle();
    bus.mem_ready = 1'b0;
    checkCycle("sw_wait1", 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 0);
    nextCycle();
    checkCycle("sw_wait2", 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 0);
    nextCycle();
    bus.mem_ready = 1'b1;
    checkCycle("sw_ready", 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0, 1, 0);
    nextCycle();
    checkOutput("sw_instret", bus.instret, 32'd2);

    runAlu("or",   7'b0110011, 3'b110, 1'b0, 3'b011, 2'b00, 3);
    runAlu("sub",  7'b0110011, 3'b000, 1'b1, 3'b001, 2'b00, 4);
    runAlu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000, 2'b01, 5);
    runAlu("and",  7'b0110011, 3'b111, 1'b0, 3'b010, 2'b00, 6);
    runAlu("slti", 7'b0010011, 3'b010, 1'b0, 3'b101, 2'b01, 7);

    runBeq("beq_taken", 1'b1, 8);
    runBeq("beq_not",   1'b0, 9);

    // jal: 4 cycles through JAL then ALUWB
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
    checkCycle("jal_fetch", 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 2'b11, 0, 0, 0);
    nextCycle();
    checkCycle("jal_decode", 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b11, 0, 0, 0);
    nextCycle();
    checkCycle("jal_jal", 1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b11, 0, 0, 0);
    nextCycle();
    checkCycle("jal_wb", 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b11, 1, 1, 0);
    nextCycle();
    checkOutput("jal_instret", bus.instret, 32'd10);

    // Unsupported opcode, with one FETCH stall before it proceeds
    applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
    checkCycle("ill_stall", 0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    nextCycle();
    bus.mem_ready = 1'b1;
    checkCycle("ill_fetch", 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    nextCycle();
    checkCycle("ill_decode", 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 1);
    nextCycle();
    checkCycle("ill_back", 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    checkOutput("ill_instret", bus.instret, 32'd10);

    // Asynchronous reset in the middle of a stalled store
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    nextCycle();
    bus.mem_ready = 1'b0;
    checkCycle("rst_pre", 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 0);
    reset = 1'b1;
    checkCycle("rst_fetch", 0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 2'b10, 2'b01, 0, 0, 0);
    checkOutput("rst_instret", bus.instret, 32'd0);
    nextCycle();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    checkCycle("rst_resume", 1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 2'b01, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit for the multicycle RV32I datapath variant: one shared memory, one ALU, instruction/data registers.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath select and enable lines, and waits on a memory ready handshake.
- Decodes lw, sw, R-type, I-type ALU, beq and jal. Any other opcode is flagged illegal and skipped.

Parameters:
- RESET_STATE, 4'd0, state encoding entered on reset (FETCH).
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  7  instruction opcode field, Instr[6:0].
- funct3  input  3  Instr[14:12].
- funct7b5  input  1  Instr[30].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register and OldPC enable.
- result_src  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  output  1  register file write enable.
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
- illegal  output  1  one-cycle pulse in DECODE when the opcode is unsupported.
- instret  output  INSTRET_W  count of completed legal instructions.

Behaviour:
- Moore FSM. State register is asynchronously reset to FETCH.
- While reset is high, all enables are 0: pc_write, mem_write, ir_write, reg_write, instr_done, illegal. Selects take their FETCH values. instret = 0.
- States, listed as outputs then next state. Unlisted selects are 00/0. alu_op is internal.
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_write are asserted only when mem_ready=1. Next state: stay if !mem_ready, else DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> FETCH, with illegal=1.
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state: MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Next state: hold until mem_ready, then MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_done=1. Next state: FETCH.
  - MEMWRITE: adr_src=1, mem_write=1 held until mem_ready. instr_done=1 in the mem_ready cycle. Next state: FETCH when mem_ready.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next state: ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next state: ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_done=1. Next state: FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, instr_done=1. Next state: FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next state: ALUWB.
- imm_src is combinational from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- ALU decode:
  - alu_op 00 -> add.
  - alu_op 01 -> sub.
  - alu_op 10, by funct3:
    - 000: sub if op[5] and funct7b5, else add
    - 010: slt
    - 110: or
    - 111: and
    - other: add.
- instret increments by 1 (wrapping) on every instr_done cycle. Unsupported opcodes do not increment it.
- Latency with mem_ready tied high: lw 5 cycles, sw 4, R/I 4, jal 4, beq 3, illegal 2.
- Reset asserted mid-instruction returns to FETCH immediately and drops any pending mem_write.
- mem_ready has no effect outside FETCH, MEMREAD and MEMWRITE.
- Unused state encodings go to FETCH on the next clock.

Test Plan:
- Apply reset, release it with mem_ready=1, op=0000011, funct3=010 (lw x6,-4(x9)). Expect states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. Expect imm_src=00, alu_control=000 in MEMADR, reg_write=1 and result_src=01 in MEMWB, then instret=1.
- op=0100011 (sw x6,8(x9)) with mem_ready low for 2 cycles in MEMWRITE. Expect mem_write=1 for 3 cycles and adr_src=1, imm_src=01, instr_done only in the ready cycle, total 6 cycles.
- op=0110011, funct3=110, funct7b5=0 (or x4,x5,x6). Expect EXECR with alu_control=011 and alu_src_b=00, then ALUWB with reg_write=1. Repeat with funct3=000, funct7b5=1: expect alu_control=001.
- op=1100011 (beq x4,x4): zero=1 gives pc_write=1 in BEQ; zero=0 gives pc_write=0. Both take 3 cycles and give imm_src=10.
- op=1101111 (jal): expect JAL with pc_write=1, then ALUWB with reg_write=1, 4 cycles. op=1111111: expect illegal pulse in DECODE, return to FETCH, instret unchanged.
- Assert reset asynchronously during MEMWRITE with mem_ready=0. Expect mem_write to fall immediately, the state to be FETCH and instret=0.
